approx_add_monitor: RTL and testbench

Streaming, parametrised evaluation block for the lower-part-OR approximate adder. It accepts operand pairs over a valid/ready handshake and computes the exact and approximate sums in a two-stage pipeline. It emits both sums with their absolute error, and keeps running error statistics (sample count, erroneous-sample count, maximum error, accumulated error). It sits between an operand source (LFSR or test DMA) and a result sink, and is used for hardware characterisation of approximation levels.

---
 rtl/approx_add_monitor.sv | 136 +++++++++++++
 tb/tb_approx_add_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_monitor.sv
// Lower-part-OR approximate adder evaluator: two-stage valid/ready pipeline
// producing exact/approximate sums, their absolute error and running statistics.
module approx_add_monitor #(
    parameter int WIDTH     = 32,
    parameter int APPROX_LV = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH:0]               sum_exact,
    output logic [WIDTH:0]               sum_approx,
    output logic [WIDTH:0]               err,
    input  logic                         stat_clear,
    output logic [CNT_WIDTH-1:0]         sample_count,
    output logic [CNT_WIDTH-1:0]         error_count,
    output logic [WIDTH:0]               max_error,
    output logic [WIDTH+CNT_WIDTH-1:0]   err_accum
);
    localparam int L  = APPROX_LV;
    localparam int AW = WIDTH + CNT_WIDTH;

    logic [WIDTH:0] exact_c, approx_c;
    assign exact_c = {1'b0, a} + {1'b0, b};

    generate
        if (L == 0) begin : g_exact
            assign approx_c = exact_c;
        end else if (L == WIDTH) begin : g_full
            assign approx_c = {a[WIDTH-1] & b[WIDTH-1], a | b};
        end else begin : g_lpo
            logic            ci;
            logic [WIDTH-L:0] hi;
            assign ci       = a[L-1] & b[L-1];
            assign hi       = {1'b0, a[WIDTH-1:L]} + {1'b0, b[WIDTH-1:L]} + {{(WIDTH-L){1'b0}}, ci};
            assign approx_c = {hi, a[L-1:0] | b[L-1:0]};
        end
    endgenerate

    logic           s1_vld_q, s2_vld_q;
    logic [WIDTH:0] s1_exact_q, s1_approx_q;
    logic [WIDTH:0] s2_exact_q, s2_approx_q, s2_err_q;
    logic           adv;

    assign adv      = !s2_vld_q || out_ready;
    assign in_ready = adv;

    // Magnitude of a WIDTH+2-bit signed difference always fits in WIDTH+1 bits.
    logic [WIDTH+1:0] diff_c;
    logic [WIDTH:0]   err_c;
    assign diff_c = {1'b0, s1_exact_q} - {1'b0, s1_approx_q};
    assign err_c  = diff_c[WIDTH+1] ? (~diff_c[WIDTH:0] + (WIDTH+1)'(1)) : diff_c[WIDTH:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q    <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            s2_vld_q    <= 1'b0;
            s2_exact_q  <= '0;
            s2_approx_q <= '0;
            s2_err_q    <= '0;
        end else if (adv) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                s1_exact_q  <= exact_c;
                s1_approx_q <= approx_c;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_exact_q  <= s1_exact_q;
                s2_approx_q <= s1_approx_q;
                s2_err_q    <= err_c;
            end
        end
    end

    assign out_valid  = s2_vld_q;
    assign sum_exact  = s2_exact_q;
    assign sum_approx = s2_approx_q;
    assign err        = s2_err_q;

    logic                 fire;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, ecnt_q, ecnt_d, cnt_b, ecnt_b;
    logic [WIDTH:0]       max_q, max_d, max_b;
    logic [AW-1:0]        acc_q, acc_d, acc_b;
    logic [AW:0]          acc_sum;

    assign fire = s2_vld_q && out_ready;

    // Clear zeroes the base; a coincident fire is then applied on top of it.
    always_comb begin
        cnt_b   = stat_clear ? '0 : cnt_q;
        ecnt_b  = stat_clear ? '0 : ecnt_q;
        max_b   = stat_clear ? '0 : max_q;
        acc_b   = stat_clear ? '0 : acc_q;
        cnt_d   = cnt_b;
        ecnt_d  = ecnt_b;
        max_d   = max_b;
        acc_d   = acc_b;
        acc_sum = {1'b0, acc_b} + {{CNT_WIDTH{1'b0}}, s2_err_q};
        if (fire) begin
            if (!(&cnt_b))
                cnt_d = cnt_b + CNT_WIDTH'(1);
            if (s2_err_q != '0 && !(&ecnt_b))
                ecnt_d = ecnt_b + CNT_WIDTH'(1);
            if (s2_err_q > max_b)
                max_d = s2_err_q;
            acc_d = acc_sum[AW] ? '1 : acc_sum[AW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            ecnt_q <= '0;
            max_q  <= '0;
            acc_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ecnt_q <= ecnt_d;
            max_q  <= max_d;
            acc_q  <= acc_d;
        end
    end

    assign sample_count = cnt_q;
    assign error_count  = ecnt_q;
    assign max_error    = max_q;
    assign err_accum    = acc_q;
endmodule

// File: tb/tb_approx_add_monitor.sv
// Self-checking bench for approx_add_monitor: directed cases, random streams with
// back-pressure, mid-stream reset and a parameter sweep (L=0 and L=WIDTH=8).
module tb_approx_add_monitor;
    logic clk = 0, reset = 0;
    always #5 clk = ~clk;

    logic        in_valid = 0, in_ready, out_valid, out_ready = 1, stat_clear = 0;
    logic [31:0] a = 0, b = 0;
    logic [32:0] sum_exact, sum_approx, err, max_error;
    logic [15:0] sample_count, error_count;
    logic [47:0] err_accum;

    logic        v0 = 0, r0, ov0, v8 = 0, r8, ov8, rdy_x = 1, clr_x = 0;
    logic [31:0] a0 = 0, b0 = 0;
    logic [32:0] e0, x0, d0, mx0;
    logic [15:0] c0, ec0;
    logic [47:0] ac0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [8:0]  e8, x8, d8, mx8;
    logic [3:0]  c8, ec8;
    logic [11:0] ac8;

    approx_add_monitor #(.WIDTH(32), .APPROX_LV(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum_exact(sum_exact), .sum_approx(sum_approx),
        .err(err), .stat_clear(stat_clear), .sample_count(sample_count), .error_count(error_count),
        .max_error(max_error), .err_accum(err_accum));

    approx_add_monitor #(.WIDTH(32), .APPROX_LV(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_ready(r0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(rdy_x), .sum_exact(e0), .sum_approx(x0),
        .err(d0), .stat_clear(clr_x), .sample_count(c0), .error_count(ec0),
        .max_error(mx0), .err_accum(ac0));

    approx_add_monitor #(.WIDTH(8), .APPROX_LV(8), .CNT_WIDTH(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(rdy_x), .sum_exact(e8), .sum_approx(x8),
        .err(d8), .stat_clear(clr_x), .sample_count(c8), .error_count(ec8),
        .max_error(mx8), .err_accum(ac8));

    int n_chk = 0, n_fail = 0;
    longint unsigned m_cnt = 0, m_ecnt = 0, m_max = 0, m_acc = 0;

    // Arithmetic reference of the lower-part-OR adder.
    function automatic longint unsigned ref_approx(longint unsigned x, longint unsigned y, int l);
        longint unsigned lo, hi, ci;
        if (l == 0) return x + y;
        lo = (x | y) & ((64'd1 << l) - 1);
        ci = (x >> (l - 1)) & (y >> (l - 1)) & 1;
        hi = (x >> l) + (y >> l) + ci;
        return (hi << l) | lo;
    endfunction

    function automatic longint unsigned ref_err(longint unsigned x, longint unsigned y, int l);
        longint unsigned e = x + y, p = ref_approx(x, y, l);
        return (e > p) ? e - p : p - e;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_ecnt = 0; m_max = 0; m_acc = 0;
    endtask

    task automatic model_fire(input longint unsigned e);
        if (m_cnt < 65535) m_cnt++;
        if (e != 0 && m_ecnt < 65535) m_ecnt++;
        if (e > m_max) m_max = e;
        m_acc = (m_acc + e > 48'hFFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : m_acc + e;
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_hs: got %b want 01", {out_valid, in_ready}); end
        n_chk++; if ({sum_exact, sum_approx, err} !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", sum_exact, sum_approx, err); end
        n_chk++; if (sample_count !== 0 || error_count !== 0 || max_error !== 0 || err_accum !== 0) begin
            n_fail++; $display("FAIL reset_stats: got %0d %0d %h %h want 0", sample_count, error_count, max_error, err_accum); end
        @(negedge clk); reset = 1;
        model_clear();
    endtask

    task automatic test_latency();
        @(negedge clk); a = 32'h0000FFFF; b = 32'h1; in_valid = 1; out_ready = 1;
        @(negedge clk); in_valid = 0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0", out_valid); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || sum_exact !== 33'h0_00010000 || sum_approx !== 33'h0_0000FFFF || err !== 33'h1) begin
            n_fail++; $display("FAIL lat_result: got v=%b %h %h %h want 1 000010000 00000ffff 1", out_valid, sum_exact, sum_approx, err); end
        model_fire(1);
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_bubble: got %b want 0", out_valid); end
        n_chk++; if (sample_count !== 1 || error_count !== 1 || max_error !== 1 || err_accum !== 1) begin
            n_fail++; $display("FAIL lat_stats: got %0d %0d %h %h want 1 1 1 1", sample_count, error_count, max_error, err_accum); end
    endtask

    task automatic test_overflow();
        @(negedge clk); a = 32'hFFFFFFFF; b = 32'h1; in_valid = 1;
        @(negedge clk); in_valid = 0;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || sum_exact !== 33'h1_00000000 || sum_approx !== 33'h0_FFFFFFFF || err !== 33'h1) begin
            n_fail++; $display("FAIL overflow: got v=%b %h %h %h want 1 100000000 0ffffffff 1", out_valid, sum_exact, sum_approx, err); end
        model_fire(1);
        @(negedge clk);
    endtask

    task automatic test_stats();
        @(negedge clk); stat_clear = 1; model_clear();
        @(negedge clk); stat_clear = 0; a = 32'h00008000; b = 32'h00008000; in_valid = 1;
        @(negedge clk); a = 32'h12340000; b = 32'h00010000;
        @(negedge clk); in_valid = 0;
        n_chk++; if (out_valid !== 1'b1 || sum_exact !== 33'h0_00010000 || sum_approx !== 33'h0_00018000 || err !== 33'h8000) begin
            n_fail++; $display("FAIL stats_p1: got v=%b %h %h %h want 1 000010000 000018000 8000", out_valid, sum_exact, sum_approx, err); end
        model_fire(32'h8000);
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || sum_exact !== 33'h0_12350000 || sum_approx !== 33'h0_12350000 || err !== 33'h0) begin
            n_fail++; $display("FAIL stats_p2: got v=%b %h %h %h want 1 012350000 012350000 0", out_valid, sum_exact, sum_approx, err); end
        model_fire(0);
        @(negedge clk);
        n_chk++; if (sample_count !== 2 || error_count !== 1 || max_error !== 33'h8000 || err_accum !== 48'h8000) begin
            n_fail++; $display("FAIL stats_vals: got %0d %0d %h %h want 2 1 8000 8000", sample_count, error_count, max_error, err_accum); end
    endtask

    task automatic test_clear_collision();
        @(negedge clk); a = 32'h5; b = 32'h5; in_valid = 1; out_ready = 0;
        @(negedge clk); in_valid = 0;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || err !== 33'h5 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL coll_setup: got v=%b err=%h rdy=%b want 1 5 0", out_valid, err, in_ready); end
        out_ready = 1; stat_clear = 1;
        model_clear(); model_fire(5);
        @(negedge clk); stat_clear = 0;
        n_chk++; if (sample_count !== 1 || error_count !== 1 || max_error !== 33'h5 || err_accum !== 48'h5) begin
            n_fail++; $display("FAIL coll_stats: got %0d %0d %h %h want 1 1 5 5", sample_count, error_count, max_error, err_accum); end
    endtask

    task automatic test_stream(input int n, input bit toggle);
        longint unsigned qa[$], qb[$];
        longint unsigned ex, xa, ee;
        logic [32:0] h_e, h_x, h_r;
        bit held = 0, pend = 0;
        int sent = 0, got = 0, cyc = 0;
        bit [3:0] pat = 4'b1001;
        @(negedge clk); stat_clear = 1; out_ready = 0; in_valid = 0; model_clear();
        @(negedge clk); stat_clear = 0;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            if (held) begin
                n_chk++;
                if (out_valid !== 1'b1 || sum_exact !== h_e || sum_approx !== h_x || err !== h_r) begin
                    n_fail++; $display("FAIL stream_hold: got v=%b %h %h %h want 1 %h %h %h", out_valid, sum_exact, sum_approx, err, h_e, h_x, h_r); end
            end
            out_ready = toggle ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            held = 0;
            if (out_valid === 1'b1) begin
                n_chk++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL stream_spurious: got out_valid=1 want 0 (nothing outstanding)");
                end else begin
                    ex = qa[0] + qb[0]; xa = ref_approx(qa[0], qb[0], 16); ee = ref_err(qa[0], qb[0], 16);
                    if (sum_exact !== 33'(ex) || sum_approx !== 33'(xa) || err !== 33'(ee)) begin
                        n_fail++; $display("FAIL stream_data: got %h %h %h want %h %h %h", sum_exact, sum_approx, err, 33'(ex), 33'(xa), 33'(ee)); end
                    if (out_ready) begin
                        void'(qa.pop_front()); void'(qb.pop_front()); got++; model_fire(ee);
                    end else begin
                        held = 1; h_e = sum_exact; h_x = sum_approx; h_r = err;
                    end
                end
            end
            if (!pend) begin
                if (sent < n && (toggle || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1; a = $urandom; b = $urandom;
                end else in_valid = 0;
            end
            #1;
            n_chk++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++; $display("FAIL stream_ready: got %b want %b", in_ready, !out_valid || out_ready); end
            if (in_valid && in_ready) begin
                qa.push_back(a); qb.push_back(b); sent++; pend = 0;
            end else pend = in_valid;
            cyc++;
        end
        in_valid = 0;
        n_chk++; if (got != n) begin n_fail++; $display("FAIL stream_timeout: got %0d results want %0d", got, n); end
        @(negedge clk); out_ready = 1;
        n_chk++; if (out_valid !== 1'b0 || qa.size() != 0) begin
            n_fail++; $display("FAIL stream_extra: got v=%b pending=%0d want 0 0", out_valid, qa.size()); end
        n_chk++;
        if (sample_count !== 16'(m_cnt) || error_count !== 16'(m_ecnt) || max_error !== 33'(m_max) || err_accum !== 48'(m_acc)) begin
            n_fail++; $display("FAIL stream_stats: got %0d %0d %h %h want %0d %0d %h %h",
                sample_count, error_count, max_error, err_accum, m_cnt, m_ecnt, m_max, m_acc); end
        if (toggle) begin
            n_chk++; if (sample_count !== 16'd8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", sample_count); end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk); out_ready = 0; in_valid = 1; a = 32'h1; b = 32'h2;
        @(negedge clk); a = 32'h3; b = 32'h4;
        @(negedge clk); in_valid = 0;
        n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_full: got v=%b rdy=%b want 1 0", out_valid, in_ready); end
        #2 reset = 0;
        #1;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_exact !== '0) begin
            n_fail++; $display("FAIL rst_async: got v=%b rdy=%b sum=%h want 0 1 0", out_valid, in_ready, sum_exact); end
        n_chk++; if (sample_count !== 0 || error_count !== 0 || max_error !== 0 || err_accum !== 0) begin
            n_fail++; $display("FAIL rst_stats: got %0d %0d %h %h want 0", sample_count, error_count, max_error, err_accum); end
        model_clear();
        @(negedge clk); reset = 1; out_ready = 1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale: got %b want 0", out_valid); end
        a = 32'h00000100; b = 32'h00000200; in_valid = 1;
        @(negedge clk); in_valid = 0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale2: got %b want 0", out_valid); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || sum_exact !== 33'h300 || err !== 33'(ref_err(32'h100, 32'h200, 16))) begin
            n_fail++; $display("FAIL rst_first: got v=%b %h %h want 1 300 0", out_valid, sum_exact, err); end
        model_fire(ref_err(32'h100, 32'h200, 16));
        @(negedge clk);
    endtask

    task automatic test_sweep();
        longint unsigned q0a[$], q0b[$], q8a[$], q8b[$];
        longint unsigned k8 = 0, ek8 = 0, mxk8 = 0, ak8 = 0, e, p;
        int got0 = 0, got8 = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (ov0 === 1'b1 && q0a.size() != 0) begin
                e = q0a[0] + q0b[0];
                n_chk++; if (e0 !== 33'(e) || x0 !== 33'(e) || d0 !== 33'h0) begin
                    n_fail++; $display("FAIL l0_data: got %h %h %h want %h %h 0", e0, x0, d0, 33'(e), 33'(e)); end
                void'(q0a.pop_front()); void'(q0b.pop_front()); got0++;
            end
            if (ov8 === 1'b1 && q8a.size() != 0) begin
                e = q8a[0] + q8b[0]; p = ref_approx(q8a[0], q8b[0], 8);
                n_chk++; if (e8 !== 9'(e) || x8 !== 9'(p) || d8 !== 9'(ref_err(q8a[0], q8b[0], 8))) begin
                    n_fail++; $display("FAIL l8_data: got %h %h %h want %h %h %h", e8, x8, d8, 9'(e), 9'(p), 9'(ref_err(q8a[0], q8b[0], 8))); end
                if (got8 == 0) begin
                    n_chk++; if (x8 !== 9'h180 || d8 !== 9'h80) begin
                        n_fail++; $display("FAIL l8_corner: got %h %h want 180 80", x8, d8); end
                end
                e = ref_err(q8a[0], q8b[0], 8);
                if (k8 < 15) k8++;
                if (e != 0 && ek8 < 15) ek8++;
                if (e > mxk8) mxk8 = e;
                ak8 = (ak8 + e > 4095) ? 4095 : ak8 + e;
                void'(q8a.pop_front()); void'(q8b.pop_front()); got8++;
            end
            if (i < 40) begin
                v0 = 1; a0 = $urandom; b0 = $urandom;
                v8 = 1;
                if (i == 0) begin a8 = 8'h80; b8 = 8'h80; end
                else begin a8 = 8'($urandom); b8 = 8'($urandom); end
                q0a.push_back(a0); q0b.push_back(b0); q8a.push_back(a8); q8b.push_back(b8);
            end else begin
                v0 = 0; v8 = 0;
            end
        end
        n_chk++; if (got0 != 40 || got8 != 40) begin n_fail++; $display("FAIL sweep_count: got %0d %0d want 40 40", got0, got8); end
        n_chk++; if (c0 !== 16'd40 || ec0 !== 16'd0 || mx0 !== 33'h0 || ac0 !== 48'h0) begin
            n_fail++; $display("FAIL l0_stats: got %0d %0d %h %h want 40 0 0 0", c0, ec0, mx0, ac0); end
        n_chk++; if (c8 !== 4'd15 || ec8 !== 4'(ek8) || mx8 !== 9'(mxk8) || ac8 !== 12'(ak8)) begin
            n_fail++; $display("FAIL l8_stats: got %0d %0d %h %h want 15 %0d %h %h", c8, ec8, mx8, ac8, ek8, mxk8, ak8); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_stats();
        test_clear_collision();
        test_stream(8, 1'b1);
        test_stream(200, 1'b0);
        test_reset_midstream();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
